// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start/data/parity/stop phases in the 16x BR2 domain.
// Latency: data_valid two BR2 cycles after the stop bit is sampled; all outputs registered.
// Backpressure: none; the consumer must take the one-cycle data_valid strobe; rx_en low aborts.
module uart_rx_ctrl #(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       BR2,
  input  logic       reset_n,
  input  logic       rx_en,
  input  logic       find,
  input  logic       sampled,
  input  logic       stop,
  input  logic [8:0] rx_out,
  output logic       sample,
  output logic       store,
  output logic       count1,
  output logic       Parity_sig,
  output logic       busy,
  output logic       data_valid,
  output logic [7:0] data_out,
  output logic       parity_err,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOPB  = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic       armed_q, armed_d;
  logic       stop_low_q, stop_low_d;
  logic       sample_q, sample_d;
  logic       store_q, store_d;
  logic       count1_q, count1_d;
  logic       busy_q, busy_d;
  logic       dv_q, dv_d;
  logic [7:0] data_q, data_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;

  logic [7:0] byte_w;
  logic       par_bit_w;
  logic       perr_w;

  // Undo the shift order: the first data bit on the line sits highest in rx_out.
  always_comb begin
    byte_w = '0;
    for (int i = 0; i < 8; i++) begin
      byte_w[i] = PARITY_EN ? rx_out[8-i] : rx_out[7-i];
    end
    par_bit_w = PARITY_EN ? rx_out[0] : 1'b0;
    perr_w    = PARITY_EN ? ((^byte_w) ^ par_bit_w ^ PARITY_ODD) : 1'b0;
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    stop_low_d = stop_low_q;
    store_d    = 1'b0;
    dv_d       = 1'b0;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    case (state_q)
      IDLE: begin
        // Arm only after the line has been seen high, so a held-low line cannot retrigger.
        if (!find) armed_d = 1'b1;
        if (rx_en && armed_q && find) begin
          state_d = START;
          armed_d = 1'b0;
        end
      end
      START: begin
        if (sampled) state_d = find ? DATA : IDLE;
      end
      DATA: begin
        // A sample arriving while a strobe is still out is ignored.
        if (sampled && !store_q) store_d = 1'b1;
        if (stop && !store_q) state_d = PARITY_EN ? PARITY : STOPB;
      end
      PARITY: begin
        if (sampled && !store_q) store_d = 1'b1;
        if (store_q) state_d = STOPB;
      end
      STOPB: begin
        if (sampled) begin
          stop_low_d = find;
          state_d    = DONE;
        end
      end
      DONE: begin
        dv_d    = 1'b1;
        data_d  = byte_w;
        perr_d  = perr_w;
        ferr_d  = stop_low_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Disabling the receiver abandons the frame without a result.
    if (!rx_en) begin
      state_d = IDLE;
      store_d = 1'b0;
      dv_d    = 1'b0;
      data_d  = data_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
    end

    sample_d = state_d inside {START, DATA, PARITY, STOPB};
    count1_d = state_d inside {DATA, PARITY, STOPB};
    busy_d   = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge BR2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      stop_low_q <= 1'b0;
      sample_q   <= 1'b0;
      store_q    <= 1'b0;
      count1_q   <= 1'b0;
      busy_q     <= 1'b0;
      dv_q       <= 1'b0;
      data_q     <= 8'h00;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      stop_low_q <= stop_low_d;
      sample_q   <= sample_d;
      store_q    <= store_d;
      count1_q   <= count1_d;
      busy_q     <= busy_d;
      dv_q       <= dv_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign sample     = sample_q;
  assign store      = store_q;
  assign count1     = count1_q;
  assign Parity_sig = PARITY_EN;
  assign busy       = busy_q;
  assign data_valid = dv_q;
  assign data_out   = data_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: instance 0 even parity, instance 1 without parity.
// Each instance has a behavioural receive datapath (tick counter, bit capture, shift register).
// Serial lines are driven bit by bit, 16 BR2 ticks per bit.
module tb_uart_rx_ctrl;

  logic       BR2 = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] rx_en = 2'b11;
  logic [1:0] rxd = 2'b11;

  logic [1:0] sample_w, store_w, count1_w, psig_w, busy_w, dv_w, perr_w, ferr_w;
  logic [7:0] dout_w [2];
  logic [1:0] sampled_w, stop_w;

  logic [3:0] tick_q  [2] = '{4'd0, 4'd0};
  logic [3:0] nbits_q [2] = '{4'd0, 4'd0};
  logic [8:0] sh_q    [2] = '{9'd0, 9'd0};
  logic [1:0] cap_q = 2'b00;

  int store_cnt [2] = '{0, 0};
  int dv_cnt    [2] = '{0, 0};
  int viol_cnt  [2] = '{0, 0};

  int checks = 0;
  int errors = 0;

  always #5 BR2 = ~BR2;

  uart_rx_ctrl #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_par (
    .BR2(BR2), .reset_n(reset_n), .rx_en(rx_en[0]), .find(~rxd[0]),
    .sampled(sampled_w[0]), .stop(stop_w[0]), .rx_out(sh_q[0]),
    .sample(sample_w[0]), .store(store_w[0]), .count1(count1_w[0]),
    .Parity_sig(psig_w[0]), .busy(busy_w[0]), .data_valid(dv_w[0]),
    .data_out(dout_w[0]), .parity_err(perr_w[0]), .frame_err(ferr_w[0])
  );

  uart_rx_ctrl #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_nopar (
    .BR2(BR2), .reset_n(reset_n), .rx_en(rx_en[1]), .find(~rxd[1]),
    .sampled(sampled_w[1]), .stop(stop_w[1]), .rx_out(sh_q[1]),
    .sample(sample_w[1]), .store(store_w[1]), .count1(count1_w[1]),
    .Parity_sig(psig_w[1]), .busy(busy_w[1]), .data_valid(dv_w[1]),
    .data_out(dout_w[1]), .parity_err(perr_w[1]), .frame_err(ferr_w[1])
  );

  // Datapath status flags.
  always_comb begin
    sampled_w = '0;
    stop_w    = '0;
    for (int k = 0; k < 2; k++) begin
      sampled_w[k] = sample_w[k] && (tick_q[k] == (count1_w[k] ? 4'd15 : 4'd7));
      stop_w[k]    = (nbits_q[k] >= 4'd8);
    end
  end

  // Datapath registers: tick counter, line capture at mid-bit, shift on store.
  always @(posedge BR2) begin
    for (int k = 0; k < 2; k++) begin
      if (!sample_w[k] || sampled_w[k]) tick_q[k] <= 4'd0;
      else                              tick_q[k] <= tick_q[k] + 4'd1;
      if (sampled_w[k]) cap_q[k] <= rxd[k];
      if (!sample_w[k]) begin
        nbits_q[k] <= 4'd0;
        sh_q[k]    <= 9'd0;
      end else if (store_w[k]) begin
        nbits_q[k] <= nbits_q[k] + 4'd1;
        sh_q[k]    <= {sh_q[k][7:0], cap_q[k]};
      end
    end
  end

  // Event counters sampled mid-cycle.
  always @(negedge BR2) begin
    for (int k = 0; k < 2; k++) begin
      if (store_w[k]) store_cnt[k] <= store_cnt[k] + 1;
      if (dv_w[k])    dv_cnt[k]    <= dv_cnt[k] + 1;
      if (sampled_w[k] && store_w[k]) viol_cnt[k] <= viol_cnt[k] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge BR2);
    #1;
  endtask

  // Frame bits LSB first: start, 8 data LSB first, [parity], stop, idle.
  function automatic logic [10:0] mk_frame(input int k, input logic [7:0] d,
                                           input logic par, input logic stopb);
    logic [10:0] f;
    f      = 11'h7FF;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (k == 0) begin
      f[9]  = par;
      f[10] = stopb;
    end else begin
      f[9] = stopb;
    end
    return f;
  endfunction

  task automatic drive_bits(input int k, input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rxd[k] = f[i];
      tick(16);
    end
  endtask

  task automatic chk_reset(input int k, input logic psig);
    chk($sformatf("rst%0d_sample", k), sample_w[k], 1'b0);
    chk($sformatf("rst%0d_store", k), store_w[k], 1'b0);
    chk($sformatf("rst%0d_count1", k), count1_w[k], 1'b0);
    chk($sformatf("rst%0d_busy", k), busy_w[k], 1'b0);
    chk($sformatf("rst%0d_dv", k), dv_w[k], 1'b0);
    chk($sformatf("rst%0d_dout", k), dout_w[k], 8'h00);
    chk($sformatf("rst%0d_perr", k), perr_w[k], 1'b0);
    chk($sformatf("rst%0d_ferr", k), ferr_w[k], 1'b0);
    chk($sformatf("rst%0d_psig", k), psig_w[k], psig);
  endtask

  int sb, db;

  initial begin
    #2 reset_n = 1'b0;
    tick(3);
    chk_reset(0, 1'b1);
    chk_reset(1, 1'b0);
    reset_n = 1'b1;
    tick(5);

    // Even parity 0xA5, parity bit 0, good stop.
    sb = store_cnt[0]; db = dv_cnt[0];
    drive_bits(0, mk_frame(0, 8'hA5, 1'b0, 1'b1), 11);
    tick(20);
    chk("t1_dv_count", dv_cnt[0] - db, 1);
    chk("t1_stores", store_cnt[0] - sb, 9);
    chk("t1_data", dout_w[0], 8'hA5);
    chk("t1_perr", perr_w[0], 1'b0);
    chk("t1_ferr", ferr_w[0], 1'b0);
    chk("t1_busy", busy_w[0], 1'b0);

    // Same frame, parity bit flipped.
    sb = store_cnt[0]; db = dv_cnt[0];
    drive_bits(0, mk_frame(0, 8'hA5, 1'b1, 1'b1), 11);
    tick(20);
    chk("t2_dv_count", dv_cnt[0] - db, 1);
    chk("t2_data", dout_w[0], 8'hA5);
    chk("t2_perr", perr_w[0], 1'b1);
    chk("t2_ferr", ferr_w[0], 1'b0);

    // No parity, 0x3C, stop bit low then line held low (break).
    sb = store_cnt[1]; db = dv_cnt[1];
    drive_bits(1, mk_frame(1, 8'h3C, 1'b0, 1'b0), 9);
    rxd[1] = 1'b0;
    tick(200);
    chk("t3_dv_count", dv_cnt[1] - db, 1);
    chk("t3_stores", store_cnt[1] - sb, 8);
    chk("t3_data", dout_w[1], 8'h3C);
    chk("t3_ferr", ferr_w[1], 1'b1);
    chk("t3_perr", perr_w[1], 1'b0);
    chk("t3_busy_break", busy_w[1], 1'b0);
    rxd[1] = 1'b1;
    tick(30);
    chk("t3_dv_after_high", dv_cnt[1] - db, 1);

    // Start glitch: 4 ticks low.
    sb = store_cnt[0]; db = dv_cnt[0];
    rxd[0] = 1'b0;
    tick(2);
    chk("t4_busy_start", busy_w[0], 1'b1);
    chk("t4_count1_half", count1_w[0], 1'b0);
    tick(2);
    rxd[0] = 1'b1;
    tick(40);
    chk("t4_stores", store_cnt[0] - sb, 0);
    chk("t4_dv_count", dv_cnt[0] - db, 0);
    chk("t4_busy", busy_w[0], 1'b0);

    // rx_en dropped after the 3rd data bit, then frame 0x81.
    sb = store_cnt[0]; db = dv_cnt[0];
    drive_bits(0, mk_frame(0, 8'hFF, 1'b0, 1'b1), 4);
    chk("t5_busy_mid", busy_w[0], 1'b1);
    chk("t5_stores_3", store_cnt[0] - sb, 3);
    rx_en[0] = 1'b0;
    tick(1);
    chk("t5_busy_off", busy_w[0], 1'b0);
    chk("t5_sample_off", sample_w[0], 1'b0);
    chk("t5_store_off", store_w[0], 1'b0);
    rxd[0] = 1'b1;
    tick(20);
    chk("t5_dv_abort", dv_cnt[0] - db, 0);
    rx_en[0] = 1'b1;
    tick(5);
    sb = store_cnt[0];
    drive_bits(0, mk_frame(0, 8'h81, 1'b0, 1'b1), 11);
    tick(20);
    chk("t5_dv_count", dv_cnt[0] - db, 1);
    chk("t5_stores", store_cnt[0] - sb, 9);
    chk("t5_data", dout_w[0], 8'h81);
    chk("t5_perr", perr_w[0], 1'b0);
    chk("t5_ferr", ferr_w[0], 1'b0);

    // Asynchronous reset in DATA, then frame 0xFF.
    db = dv_cnt[0];
    drive_bits(0, mk_frame(0, 8'hFF, 1'b0, 1'b1), 5);
    reset_n = 1'b0;
    rxd[0]  = 1'b1;
    #1;
    chk_reset(0, 1'b1);
    tick(3);
    reset_n = 1'b1;
    tick(5);
    chk("t6_dv_abort", dv_cnt[0] - db, 0);
    sb = store_cnt[0];
    drive_bits(0, mk_frame(0, 8'hFF, 1'b0, 1'b1), 11);
    tick(20);
    chk("t6_dv_count", dv_cnt[0] - db, 1);
    chk("t6_stores", store_cnt[0] - sb, 9);
    chk("t6_data", dout_w[0], 8'hFF);
    chk("t6_perr", perr_w[0], 1'b0);
    chk("t6_ferr", ferr_w[0], 1'b0);

    chk("proto_viol0", viol_cnt[0], 0);
    chk("proto_viol1", viol_cnt[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Sequencing controller for the UART receive datapath. It watches the datapath status (`find`, `sampled`, `stop`) and drives its controls (`sample`, `store`, `count1`, `Parity_sig`) through start, data, optional parity and stop-bit phases. When a frame completes it reorders the 9-bit shift register into a byte, checks parity and framing, and issues a one-cycle result strobe to the consumer. It sits between the receive datapath and the host-side logic, all in the BR2 (16x oversample) domain.

## Interface
- `PARITY_EN`, default 1: 1 adds a parity bit after the 8 data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.

Ports:
- `BR2`  in  1  oversample clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_en`  in  1  receiver enable.
- `find`  in  1  datapath flag, 1 when the serial line is low.
- `sampled`  in  1  datapath flag, 1 when the sample counter is at its terminal count.
- `stop`  in  1  datapath flag, 1 when 8 bits have been stored.
- `rx_out`  in  9  datapath shift register.
- `sample`  out  1  sample counter enable and line capture.
- `store`  out  1  shift strobe, one cycle wide.
- `count1`  out  1  0 selects an 8-tick half-bit, 1 selects a 16-tick full bit.
- `Parity_sig`  out  1  equals `PARITY_EN`; constant.
- `busy`  out  1  1 in any state other than IDLE.
- `data_valid`  out  1  one-cycle result strobe.
- `data_out`  out  8  received byte, LSB is the first data bit on the line.
- `parity_err`  out  1  qualified by `data_valid`.
- `frame_err`  out  1  qualified by `data_valid`.

## Operation
- States: IDLE, START, DATA, PARITY, STOPB, DONE. All outputs are registered.
- IDLE: `sample`=0, `count1`=0.
  - An internal `armed` flag sets on any cycle with `find`=0.
  - When `rx_en`=1, `armed`=1 and `find`=1, go to START and clear `armed`.
- START: `sample`=1, `count1`=0 (half bit). On `sampled`=1:
  - `find`=1 → DATA.
  - `find`=0 → glitch, return to IDLE with no result.
- DATA: `sample`=1, `count1`=1.
  - Each `sampled`=1 produces a `store` pulse on the next cycle.
  - When `stop`=1 and no `store` is pending → PARITY if `PARITY_EN`, else STOPB.
- PARITY: same as DATA for exactly one bit (one `store` pulse), then STOPB.
- STOPB: `sample`=1, `count1`=1. On `sampled`=1 latch `frame_err` = `find` (stop bit low), then go to DONE.
- DONE: for one cycle assert `data_valid` with `data_out`, `parity_err` and `frame_err`, then go to IDLE.
  - `armed` stays clear until the line is seen high, so a stuck-low line (break) gives one frame error, not repeated frames.
- Bit order in `rx_out`, since the first bit received shifts to the highest occupied position:
  - With parity: `data_out[i]` = `rx_out[8-i]`; parity bit = `rx_out[0]`.
  - Without parity: `data_out[i]` = `rx_out[7-i]`.
- `parity_err` = XOR of the 8 data bits and the parity bit, XOR `PARITY_ODD`. Forced to 0 when `PARITY_EN`=0.
- `rx_en` falling in any state: return to IDLE next cycle with no `data_valid`; `sample` and `store` drop to 0.
- `data_out`, `parity_err` and `frame_err` hold their last values between strobes.

## Timing
- Reset: state IDLE, `armed`=0, and every output 0 except `Parity_sig`, which equals `PARITY_EN` at all times.
- `store` rises one BR2 cycle after the cycle where `sampled`=1 is seen in DATA or PARITY, and lasts exactly one cycle.
- `sampled` seen while `store` is already high is a protocol violation. The controller ignores it; the bench must flag it.
- `data_valid` rises 2 cycles after `sampled`=1 is seen in STOPB (one cycle to enter DONE, one registered output).
- From the start edge to `data_valid`, nominal frame: 8 + 16×(8 + `PARITY_EN` + 1) ticks plus the fixed 3–4 cycle pipeline.
- Asynchronous reset mid-frame: outputs go to reset values at once, with no result.

## Test plan
- Even parity, byte 0xA5 (parity bit 0), stop bit 1 → `data_valid` pulse, `data_out`=0xA5, `parity_err`=0, `frame_err`=0, and exactly 9 `store` pulses.
- Same frame with the parity bit flipped to 1 → `data_out`=0xA5, `parity_err`=1.
- `PARITY_EN`=0, byte 0x3C with the stop bit held low → `data_out`=0x3C, `frame_err`=1, 8 `store` pulses. Holding the line low afterwards yields no further `data_valid` until the line goes high.
- Start glitch: line low for 4 ticks then high → return to IDLE after the half bit, 0 `store` pulses, no `data_valid`.
- `rx_en` dropped after the 3rd data bit → IDLE next cycle, `busy`=0, no `data_valid`. The next full frame 0x81 is received correctly.
- `reset_n` asserted mid-DATA → all outputs 0 immediately. After release, frame 0xFF decodes with no errors.
